md_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS core, sitting in the E stage directly downstream of the instruction decoder. It consumes the decoder's 4-bit `mdop` code with the forwarded rs/rt operands and runs multi-cycle mult/multu/div/divu. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo. It drives `start`/`busy` to the hazard unit, which stalls D-stage md-class instructions while either is high.

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_unit_if.sv | 19 +
 rtl/md_busy_cnt.sv | 35 +++
 rtl/md_unit.sv | 113 +++++++++++
 tb/tb_md_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the E-stage multiply/divide unit.
//   - mdop codes driven by the instruction decoder
//   - default busy latencies for multiply and divide
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_MULTU = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the four codes that launch a multi-cycle operation.
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MULTU) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   mdop  : operation code from the decoder
//   A, B  : forwarded rs / rt operands
//   start : operation accepted this cycle (combinational, to hazard unit)
//   busy  : operation in flight (registered, to hazard unit)
//   HI/LO : architectural HI/LO registers (mfhi/mflo read data)
// master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic [3:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output mdop, A, B, input start, busy, HI, LO);
  modport slave  (input mdop, A, B, output start, busy, HI, LO);
endinterface

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: loadable down-counter that times the busy window.
//   clk, rstn : clock, async active-low reset
//   load      : load load_val at this edge (only asserted while idle)
//   load_val  : number of busy cycles
//   busy      : registered, high while the count is nonzero
//   done      : high in the last busy cycle; the edge ending it takes 1 -> 0
module md_busy_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= (load_val != '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      busy <= (cnt != W'(1));
    end
  end

  assign done = busy && (cnt == W'(1));

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, rstn : clock, async active-low reset
//   md        : md_unit_if.slave (mdop, A, B in; start, busy, HI, LO out)
// The result is computed combinationally at the start edge and parked in
// pending registers; HI/LO take it when the busy counter expires, so the
// architectural registers only change at the end of the busy window.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rstn,
  md_unit_if.slave  md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic        start;
  logic        busy;
  logic        done;
  logic        is_mul;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_we;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic               div_ovf;
  logic        [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        [31:0] res_hi, res_lo;
  logic               res_we;

  assign start  = is_md_start_op(md.mdop) && !busy;
  assign is_mul = (md.mdop == MD_MULT) || (md.mdop == MD_MULTU);

  md_busy_cnt #(.W(CNT_W)) u_busy_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (start),
    .load_val (is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES)),
    .busy     (busy),
    .done     (done)
  );

  assign prod_s = $signed(md.A) * $signed(md.B);
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  // A zero divisor is swapped for 1 so the dividers never see it; the
  // result is discarded via res_we anyway. The one signed overflow case
  // is pinned explicitly rather than left to the divider's wraparound.
  assign divisor = (md.B != 32'd0) ? md.B : 32'd1;
  assign div_ovf = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = 32'($signed(md.A) / $signed(divisor));
    rem_s = 32'($signed(md.A) % $signed(divisor));
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end
  end

  assign quo_u = md.A / divisor;
  assign rem_u = md.A % divisor;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    case (md.mdop)
      MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV:   begin res_hi = rem_s; res_lo = quo_s; res_we = (md.B != 32'd0); end
      MD_DIVU:  begin res_hi = rem_u; res_lo = quo_u; res_we = (md.B != 32'd0); end
      default:  res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_we <= res_we;
      end
      if (done) begin
        if (pend_we) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end else if (!busy) begin
        if (md.mdop == MD_MTHI) hi_q <= md.A;
        if (md.mdop == MD_MTLO) lo_q <= md.A;
      end
    end
  end

  assign md.start = start;
  assign md.busy  = busy;
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  md_unit_if md();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .md   (md)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: architectural result of one md operation.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      MD_DIVU:  if (b != 0) begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!md.busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Issue a start op in the first idle cycle; returns one tick after the start edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    md.mdop = op; md.A = a; md.B = b;
    #1;
    chk("start_idle", md.start, 1);
    e.hi = hi_m; e.lo = lo_m;
    model(op, a, b, e.hi, e.lo);
    hi_m = e.hi; lo_m = e.lo;
    e.len = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    exp_q.push_back(e);
    @(posedge clk); #1;
    md.mdop = MD_NONE;
    chk("busy_rise", md.busy, 1);
  endtask

  // Idle mthi/mtlo write, checked the following cycle.
  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    wait_idle();
    md.mdop = op; md.A = a;
    #1;
    chk("mt_no_start", md.start, 0);
    if (op == MD_MTHI) hi_m = a; else lo_m = a;
    @(posedge clk); #1;
    md.mdop = MD_NONE;
    @(negedge clk);
    if (op == MD_MTHI) chk("mthi_value", md.HI, a);
    else               chk("mtlo_value", md.LO, a);
  endtask

  // Monitor: every busy falling edge presents one completed operation.
  initial begin : monitor
    logic        busy_prev;
    logic [31:0] hi0, lo0;
    logic        win_bad;
    int          run;
    exp_t        e;
    busy_prev = 1'b0; run = 0; win_bad = 1'b0; hi0 = '0; lo0 = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        busy_prev = 1'b0; run = 0; win_bad = 1'b0;
      end else begin
        if (md.busy) begin
          if (!busy_prev) begin hi0 = md.HI; lo0 = md.LO; end
          else if (md.HI !== hi0 || md.LO !== lo0) win_bad = 1'b1;
          run++;
        end else if (busy_prev) begin
          if (exp_q.size() == 0) chk("unexpected_commit", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("commit_hi", md.HI, e.hi);
            chk("commit_lo", md.LO, e.lo);
            chk("busy_len", 64'(run), 64'(e.len));
            chk("window_stable", win_bad, 0);
          end
          run = 0; win_bad = 1'b0;
        end
        busy_prev = md.busy;
      end
    end
  end

  initial begin : stim
    logic [3:0]  op;
    logic [31:0] a, b;
    int          busy_seen;
    md.mdop = MD_NONE; md.A = '0; md.B = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_hi", md.HI, 0);
    chk("reset_lo", md.LO, 0);
    chk("reset_busy", md.busy, 0);
    chk("reset_start", md.start, 0);

    // signed mult -3 * 7
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    chk("mult_hi", md.HI, 32'hFFFF_FFFF);
    chk("mult_lo", md.LO, 32'hFFFF_FFEB);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi", md.HI, 32'h0000_0001);
    chk("multu_lo", md.LO, 32'hFFFF_FFFE);

    // div -7 / 2, then divu by zero back-to-back
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(MD_DIVU, 32'd7, 32'd0);
    wait_idle();
    chk("divz_hi_kept", md.HI, 32'hFFFF_FFFF);
    chk("divz_lo_kept", md.LO, 32'hFFFF_FFFD);

    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("div_ovf_lo", md.LO, 32'h8000_0000);
    chk("div_ovf_hi", md.HI, 32'h0000_0000);

    do_mt(MD_MTHI, 32'h1234_5678);

    // writes and starts while busy are ignored
    do_op(MD_MULT, 32'd3, 32'd4);
    md.mdop = MD_MTLO; md.A = 32'hCAFE_BABE;
    #1 chk("mtlo_busy_no_start", md.start, 0);
    @(posedge clk); #1;
    md.mdop = MD_MULT; md.A = 32'd9; md.B = 32'd9;
    #1 chk("mult_busy_no_start", md.start, 0);
    @(posedge clk); #1;
    md.mdop = MD_MTHI; md.A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    md.mdop = MD_NONE;
    wait_idle();
    chk("lo_after_ignored_mtlo", md.LO, 32'd12);

    // back-to-back mults
    do_op(MD_MULT, 32'd100, 32'd200);
    do_op(MD_MULTU, 32'h8000_0000, 32'h0000_0004);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 10));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) b = $urandom_range(1, 5);
      if (op <= 4) do_op(op, a, b);
      else if (op == 7 || op == 8) do_mt(op, a);
      else begin
        wait_idle();
        md.mdop = (op == 9) ? 4'($urandom_range(9, 15)) : op;
        md.A = a; md.B = b;
        #1 chk("no_start_op", md.start, 0);
        @(posedge clk); #1;
        md.mdop = MD_NONE;
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("all_ops_seen", 64'(exp_q.size()), 0);

    // reset in the middle of a mult: nothing commits afterwards
    do_op(MD_MULT, 32'd5, 32'd6);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_busy", md.busy, 0);
    chk("midreset_hi", md.HI, 0);
    chk("midreset_lo", md.LO, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (md.busy) busy_seen++;
    end
    chk("post_reset_busy", 64'(busy_seen), 0);
    chk("post_reset_hi", md.HI, 0);
    chk("post_reset_lo", md.LO, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
